// File: rtl/key_debounce_multi.sv
// Multi-channel key debouncer: 2-flop synchroniser, restart-on-bounce filter, press/release pulses.
// Optional long-press auto-repeat is compiled in with `define KEY_REPEAT_EN.
module key_debounce_multi #(
   parameter int unsigned N_KEYS          = 4,
   parameter int unsigned DEBOUNCE_CYCLES = 1000,
   parameter int unsigned CNT_W           = 21,
   parameter int unsigned ACTIVE_LOW      = 1,
   parameter int unsigned HOLD_CYCLES     = 50_000_000,
   parameter int unsigned REPEAT_CYCLES   = 10_000_000
) (
   input  logic              clk,
   input  logic              key_reset,
   input  logic [N_KEYS-1:0] key_in,
   output logic [N_KEYS-1:0] key_level,
   output logic [N_KEYS-1:0] key_press,
   output logic [N_KEYS-1:0] key_release,
   output logic [N_KEYS-1:0] key_repeat
);

   typedef enum logic {IDLE, CHECK} state_e;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   if (DEBOUNCE_CYCLES < 2 || 64'(DEBOUNCE_CYCLES) > (64'd1 << CNT_W) ||
       REPEAT_CYCLES < 1 || REPEAT_CYCLES > HOLD_CYCLES) begin : g_bad_param
      $error("key_debounce_multi: illegal parameter combination");
   end

   logic [N_KEYS-1:0] norm_c;
   logic [N_KEYS-1:0] sync1_q, sync2_q;
   state_e            state_q [N_KEYS];
   state_e            state_d [N_KEYS];
   logic [CNT_W-1:0]  cnt_q   [N_KEYS];
   logic [CNT_W-1:0]  cnt_d   [N_KEYS];
   logic [N_KEYS-1:0] level_q, level_d;
   logic [N_KEYS-1:0] press_q, press_d;
   logic [N_KEYS-1:0] release_q, release_d;

   assign norm_c = (ACTIVE_LOW != 0) ? ~key_in : key_in;

   // Synchroniser; resets to the released value
   always_ff @(posedge clk or negedge key_reset) begin
      if (!key_reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= norm_c;
         sync2_q <= sync1_q;
      end
   end

   always_ff @(posedge clk or negedge key_reset) begin
      if (!key_reset) begin
         for (int i = 0; i < N_KEYS; i++) begin
            state_q[i] <= IDLE;
            cnt_q[i]   <= '0;
         end
         level_q   <= '0;
         press_q   <= '0;
         release_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
      end
   end

   // Per-channel filter: any sample equal to the current level during CHECK restarts the window
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      level_d   = level_q;
      press_d   = '0;
      release_d = '0;
      for (int i = 0; i < N_KEYS; i++) begin
         case (state_q[i])
            IDLE: begin
               cnt_d[i] = '0;
               if (sync2_q[i] != level_q[i]) state_d[i] = CHECK;
            end
            CHECK: begin
               if (sync2_q[i] == level_q[i]) begin
                  state_d[i] = IDLE;
                  cnt_d[i]   = '0;
               end else if (cnt_q[i] == CNT_LAST) begin
                  level_d[i]   = sync2_q[i];
                  press_d[i]   = sync2_q[i];
                  release_d[i] = ~sync2_q[i];
                  state_d[i]   = IDLE;
                  cnt_d[i]     = '0;
               end else begin
                  cnt_d[i] = cnt_q[i] + CNT_W'(1);
               end
            end
            default: begin
               state_d[i] = IDLE;
               cnt_d[i]   = '0;
            end
         endcase
      end
   end

   assign key_level   = level_q;
   assign key_press   = press_q;
   assign key_release = release_q;

`ifdef KEY_REPEAT_EN
   localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);

   logic [HOLD_W-1:0] hold_q [N_KEYS];
   logic [HOLD_W-1:0] hold_d [N_KEYS];
   logic [N_KEYS-1:0] repeat_q, repeat_d;

   // Hold counter tracks the debounced level; reloading keeps the REPEAT_CYCLES cadence
   always_comb begin
      repeat_d = '0;
      for (int i = 0; i < N_KEYS; i++) begin
         hold_d[i] = '0;
         if (level_q[i]) begin
            if (hold_q[i] == HOLD_W'(HOLD_CYCLES - 1)) begin
               hold_d[i]   = HOLD_W'(HOLD_CYCLES - REPEAT_CYCLES);
               repeat_d[i] = ~release_d[i];
            end else begin
               hold_d[i] = hold_q[i] + HOLD_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge key_reset) begin
      if (!key_reset) begin
         for (int i = 0; i < N_KEYS; i++) hold_q[i] <= '0;
         repeat_q <= '0;
      end else begin
         hold_q   <= hold_d;
         repeat_q <= repeat_d;
      end
   end

   assign key_repeat = repeat_q;
`else
   assign key_repeat = '0;
`endif

endmodule
